// File: rtl/router_port_driver.sv
// Serial packet driver for one router input port: address, pad, then LSB-first payload on din/frame_n/valid_n.
// Optional destination-busy wait before the address is enabled by defining ROUTER_DRV_BUSY_WAIT_EN.
module router_port_driver #(
    parameter int ADDR_W     = 4,
    parameter int PAD_CYCLES = 5,
    parameter int BYTE_W     = 8,
    parameter int CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    input  logic [BYTE_W-1:0]    byte_data,
    input  logic                 byte_last,
    input  logic [2**ADDR_W-1:0] busy_n,
    output logic                 din,
    output logic                 frame_n,
    output logic                 valid_n,
    output logic                 pkt_done,
    output logic [CNT_W-1:0]     pkt_count,
    output logic [2:0]           dbg_state
);

    localparam int MAXC = (ADDR_W > PAD_CYCLES)
                        ? ((ADDR_W > BYTE_W) ? ADDR_W : BYTE_W)
                        : ((PAD_CYCLES > BYTE_W) ? PAD_CYCLES : BYTE_W);
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] PAD_LAST  = CW'(PAD_CYCLES - 1);
    localparam logic [CW-1:0] BYTE_LAST = CW'(BYTE_W - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WAIT = 3'd1,
        S_ADDR = 3'd2,
        S_PAD  = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] sym_q, sym_d;
    logic              last_q, last_d;
    logic [CNT_W-1:0]  pkt_count_q;
    logic              din_q, din_d;
    logic              frame_n_q, frame_n_d;
    logic              valid_n_q, valid_n_d;
    logic              pkt_done_q, done_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              byte_ready_q, byte_ready_d;
    logic              fetch;

`ifndef ROUTER_DRV_BUSY_WAIT_EN
    logic unused_busy;
    assign unused_busy = ^busy_n;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            sym_q        <= '0;
            last_q       <= 1'b0;
            pkt_count_q  <= '0;
            din_q        <= 1'b0;
            frame_n_q    <= 1'b1;
            valid_n_q    <= 1'b1;
            pkt_done_q   <= 1'b0;
            cmd_ready_q  <= 1'b0;
            byte_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            sym_q        <= sym_d;
            last_q       <= last_d;
            pkt_count_q  <= pkt_count_q + CNT_W'(done_d);
            din_q        <= din_d;
            frame_n_q    <= frame_n_d;
            valid_n_q    <= valid_n_d;
            pkt_done_q   <= done_d;
            cmd_ready_q  <= cmd_ready_d;
            byte_ready_q <= byte_ready_d;
        end
    end

    // addr_q and sym_q shift right as bits go out, so bit 0 is always the next bit to send.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sym_d   = sym_q;
        last_d  = last_q;
        done_d  = 1'b0;
        fetch   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    addr_d = cmd_addr;
                    cnt_d  = '0;
`ifdef ROUTER_DRV_BUSY_WAIT_EN
                    state_d = S_WAIT;
`else
                    state_d = S_ADDR;
`endif
                end
            end
`ifdef ROUTER_DRV_BUSY_WAIT_EN
            S_WAIT: begin
                if (busy_n[addr_q]) state_d = S_ADDR;
            end
`endif
            S_ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = S_PAD;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_q + CW'(1);
                    addr_d = addr_q >> 1;
                end
            end
            S_PAD: begin
                if (cnt_q == PAD_LAST) fetch = 1'b1;
                else                   cnt_d = cnt_q + CW'(1);
            end
            S_DATA: begin
                if (cnt_q == BYTE_LAST) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        fetch = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    sym_d = sym_q >> 1;
                end
            end
            S_GAP:   fetch = 1'b1;
            default: state_d = S_IDLE;
        endcase
        if (fetch) begin
            if (byte_valid && byte_ready_q) begin
                state_d = S_DATA;
                cnt_d   = '0;
                sym_d   = byte_data;
                last_d  = byte_last;
            end else begin
                state_d = S_GAP;
            end
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with state_q.
    always_comb begin
        din_d     = 1'b0;
        frame_n_d = 1'b1;
        valid_n_d = 1'b1;
        case (state_d)
            S_ADDR: begin
                din_d     = addr_d[0];
                frame_n_d = 1'b0;
            end
            S_PAD: begin
                din_d     = 1'b1;
                frame_n_d = 1'b0;
            end
            S_DATA: begin
                din_d     = sym_d[0];
                valid_n_d = 1'b0;
                frame_n_d = last_d && (cnt_d == BYTE_LAST);
            end
            S_GAP:   frame_n_d = 1'b0;
            default: ;
        endcase
        cmd_ready_d  = (state_d == S_IDLE);
        byte_ready_d = ((state_d == S_PAD) && (cnt_d == PAD_LAST))
                    || ((state_d == S_DATA) && (cnt_d == BYTE_LAST) && !last_d)
                    || (state_d == S_GAP);
    end

    assign din        = din_q;
    assign frame_n    = frame_n_q;
    assign valid_n    = valid_n_q;
    assign pkt_done   = pkt_done_q;
    assign pkt_count  = pkt_count_q;
    assign cmd_ready  = cmd_ready_q;
    assign byte_ready = byte_ready_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_router_port_driver.sv
// Bench for router_port_driver: default-parameter instance driven with directed and random packets,
// plus a small-parameter instance for the generalised widths and counter wrap.
module tb_router_port_driver;

    localparam int AW = 4, PW = 5, BW = 8, CW = 16;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          cmd_valid, cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          byte_valid, byte_ready, byte_last;
    logic [BW-1:0] byte_data;
    logic [15:0]   busy_n;
    logic          din, frame_n, valid_n, pkt_done;
    logic [CW-1:0] pkt_count;
    logic [2:0]    dbg_state;

    logic       p_cmd_valid, p_cmd_ready, p_byte_valid, p_byte_ready, p_byte_last;
    logic [2:0] p_cmd_addr;
    logic [3:0] p_byte_data;
    logic [7:0] p_busy_n;
    logic       p_din, p_frame_n, p_valid_n, p_pkt_done;
    logic [7:0] p_pkt_count;
    logic [2:0] p_dbg_state;

    router_port_driver dut (
        .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .byte_data(byte_data), .byte_last(byte_last), .busy_n(busy_n), .din(din),
        .frame_n(frame_n), .valid_n(valid_n), .pkt_done(pkt_done), .pkt_count(pkt_count),
        .dbg_state(dbg_state)
    );

    router_port_driver #(.ADDR_W(3), .PAD_CYCLES(2), .BYTE_W(4), .CNT_W(8)) dut_p (
        .clock(clock), .reset_n(reset_n), .cmd_valid(p_cmd_valid), .cmd_ready(p_cmd_ready),
        .cmd_addr(p_cmd_addr), .byte_valid(p_byte_valid), .byte_ready(p_byte_ready),
        .byte_data(p_byte_data), .byte_last(p_byte_last), .busy_n(p_busy_n), .din(p_din),
        .frame_n(p_frame_n), .valid_n(p_valid_n), .pkt_done(p_pkt_done), .pkt_count(p_pkt_count),
        .dbg_state(p_dbg_state)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    logic [2:0]    exp_q[$];
    logic [BW-1:0] syms[$];
    int            gaps[$];
    logic [CW-1:0] exp_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {din, frame_n, valid_n} per cycle after command acceptance.
    task automatic build_expected(input logic [AW-1:0] a, input int n, input int wait_c);
        exp_q.delete();
        for (int i = 0; i < wait_c; i++) exp_q.push_back(3'b011);
        for (int i = 0; i < AW; i++) exp_q.push_back({a[i], 1'b0, 1'b1});
        for (int i = 0; i < PW; i++) exp_q.push_back(3'b101);
        for (int s = 0; s < n; s++) begin
            logic [BW-1:0] sym;
            sym = syms[s];
            for (int g = 0; g < gaps[s]; g++) exp_q.push_back(3'b001);
            for (int b = 0; b < BW; b++)
                exp_q.push_back({sym[b], ((s == n - 1) && (b == BW - 1)), 1'b0});
        end
    endtask

    task automatic run_packet(input logic [AW-1:0] a, input int n, input int busy_low, input int abort_at);
        int idx, hold, low_cnt, exp_low, wait_c;
`ifdef ROUTER_DRV_BUSY_WAIT_EN
        wait_c = busy_low + 1;
`else
        wait_c = 0;
`endif
        build_expected(a, n, wait_c);
        exp_low = AW + PW + n * BW - 1;
        for (int s = 0; s < n; s++) exp_low += gaps[s];
        check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_addr = a;
        byte_valid = 1'b0;
        busy_n = 16'($urandom);
        @(posedge clock); #1;
        idx = 0;
        hold = gaps[0];
        low_cnt = 0;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k == abort_at) begin
                reset_n = 1'b0;
                #1;
                exp_count = '0;
                check("abort_out", 32'({din, frame_n, valid_n}), 32'(3'b011));
                check("abort_cmd_ready", 32'(cmd_ready), 32'd0);
                check("abort_byte_ready", 32'(byte_ready), 32'd0);
                check("abort_count", 32'(pkt_count), 32'(exp_count));
                cmd_valid = 1'b0;
                byte_valid = 1'b0;
                return;
            end
            check($sformatf("serial[%0d]", k), 32'({din, frame_n, valid_n}), 32'(exp_q[k]));
            if (k == 0) check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            if (!frame_n) low_cnt++;
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr = 4'($urandom);
            busy_n = 16'($urandom);
`ifdef ROUTER_DRV_BUSY_WAIT_EN
            busy_n[a] = (k >= busy_low);
`endif
            if (byte_ready && idx < n) begin
                if (hold > 0) begin
                    byte_valid = 1'b0;
                    byte_data = 8'($urandom);
                    hold--;
                end else begin
                    byte_valid = 1'b1;
                    byte_data = syms[idx];
                    byte_last = (idx == n - 1);
                    idx++;
                    hold = (idx < n) ? gaps[idx] : 0;
                end
            end else begin
                byte_valid = 1'($urandom_range(0, 1));
                byte_data = 8'($urandom);
                byte_last = 1'($urandom_range(0, 1));
            end
            @(posedge clock); #1;
        end
        exp_count++;
        check("end_idle_out", 32'({din, frame_n, valid_n}), 32'(3'b011));
        check("pkt_done", 32'(pkt_done), 32'd1);
        check("pkt_count", 32'(pkt_count), 32'(exp_count));
        check("frame_low_len", 32'(low_cnt), 32'(exp_low));
        check("cmd_ready_after", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        byte_valid = 1'b0;
    endtask

    int p_din_e[9] = '{0, 1, 1, 1, 1, 1, 0, 0, 1};
    int p_fr_e[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    int p_vn_e[9]  = '{1, 1, 1, 1, 1, 0, 0, 0, 0};

    initial begin
        int abort_k, pw, got, plow;
        logic [7:0] p_exp_count;

        // Reset with random inputs
        reset_n = 1'b0;
        exp_count = '0;
        for (int c = 0; c < 4; c++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_addr = 4'($urandom);
            byte_valid = 1'($urandom_range(0, 1));
            byte_data = 8'($urandom);
            byte_last = 1'($urandom_range(0, 1));
            busy_n = 16'($urandom);
            p_cmd_valid = 1'($urandom_range(0, 1));
            p_cmd_addr = 3'($urandom);
            p_byte_valid = 1'($urandom_range(0, 1));
            p_byte_data = 4'($urandom);
            p_byte_last = 1'($urandom_range(0, 1));
            p_busy_n = 8'($urandom);
            @(posedge clock); #1;
            check("rst_out", 32'({din, frame_n, valid_n}), 32'(3'b011));
            check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
            check("rst_byte_ready", 32'(byte_ready), 32'd0);
            check("rst_pkt_done", 32'(pkt_done), 32'd0);
            check("rst_count", 32'(pkt_count), 32'd0);
            check("p_rst_out", 32'({p_din, p_frame_n, p_valid_n}), 32'(3'b011));
        end
        cmd_valid = 1'b0;
        byte_valid = 1'b0;
        p_cmd_valid = 1'b0;
        p_byte_valid = 1'b0;
        p_busy_n = '1;
        reset_n = 1'b1;
        #1;
        check("rel_cmd_ready_0", 32'(cmd_ready), 32'd0);
        @(posedge clock); #1;
        check("rel_cmd_ready_1", 32'(cmd_ready), 32'd1);

        // Basic packet
        syms = '{8'hA5, 8'h3C};
        gaps = '{0, 0};
        run_packet(4'h5, 2, 0, -1);
        @(posedge clock); #1;
        check("pkt_done_pulse_end", 32'(pkt_done), 32'd0);

        // Underrun before the second symbol
        syms = '{8'($urandom), 8'($urandom)};
        gaps = '{0, 3};
        run_packet(4'hF, 2, 0, -1);

        // Back-to-back packets, then an aborted third
        syms = '{8'($urandom)};
        gaps = '{0};
        run_packet(4'($urandom), 1, 0, -1);
        syms = '{8'($urandom), 8'($urandom), 8'($urandom)};
        gaps = '{0, 0, 0};
        run_packet(4'($urandom), 3, 0, -1);
`ifdef ROUTER_DRV_BUSY_WAIT_EN
        abort_k = 1 + AW + PW + 3;
`else
        abort_k = AW + PW + 3;
`endif
        syms = '{8'($urandom), 8'($urandom)};
        gaps = '{0, 0};
        run_packet(4'($urandom), 2, 0, abort_k);
        #2;
        reset_n = 1'b1;
        @(posedge clock); #1;
        check("abort_rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Destination busy for 6 cycles (ignored when the option is absent)
        syms = '{8'($urandom)};
        gaps = '{0};
        run_packet(4'h2, 1, 6, -1);

        // Random packets
        for (int p = 0; p < 8; p++) begin
            int n;
            n = $urandom_range(1, 4);
            syms.delete();
            gaps.delete();
            for (int s = 0; s < n; s++) begin
                syms.push_back(8'($urandom));
                gaps.push_back($urandom_range(0, 3));
            end
            run_packet(4'($urandom), n, $urandom_range(0, 3), -1);
        end

        // Small-parameter instance: addr 6, symbol 0x9
`ifdef ROUTER_DRV_BUSY_WAIT_EN
        pw = 1;
`else
        pw = 0;
`endif
        check("p_cmd_ready", 32'(p_cmd_ready), 32'd1);
        p_cmd_valid = 1'b1;
        p_cmd_addr = 3'd6;
        p_byte_valid = 1'b1;
        p_byte_data = 4'h9;
        p_byte_last = 1'b1;
        @(posedge clock); #1;
        p_cmd_valid = 1'b0;
        plow = 0;
        for (int k = 0; k < pw; k++) begin
            check("p_wait_out", 32'({p_din, p_frame_n, p_valid_n}), 32'(3'b011));
            @(posedge clock); #1;
        end
        for (int k = 0; k < 9; k++) begin
            check($sformatf("p_serial[%0d]", k), 32'({p_din, p_frame_n, p_valid_n}),
                  32'({p_din_e[k][0], p_fr_e[k][0], p_vn_e[k][0]}));
            if (!p_frame_n) plow++;
            @(posedge clock); #1;
        end
        p_exp_count = 8'd1;
        check("p_frame_low_len", 32'(plow), 32'd8);
        check("p_pkt_done", 32'(p_pkt_done), 32'd1);
        check("p_count_1", 32'(p_pkt_count), 32'(p_exp_count));

        // Counter wrap on the 8-bit instance with commands offered continuously
        p_cmd_valid = 1'b1;
        for (int p = 0; p < 255; p++) begin
            got = 0;
            for (int c = 0; c < 40 && got == 0; c++) begin
                @(posedge clock); #1;
                if (p_pkt_done) got = 1;
            end
            if (got == 0) begin
                check("p_done_timeout", 32'(got), 32'd1);
                break;
            end
            p_exp_count++;
            if (p == 253) check("p_count_255", 32'(p_pkt_count), 32'(p_exp_count));
        end
        check("p_count_wrap", 32'(p_pkt_count), 32'(p_exp_count));
        p_cmd_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
